// File: rtl/rom_sequencer_mc.sv
// rom_sequencer_mc: multi-channel event sequencer sharing one synchronous ROM port.
// Ports: clk, reset (async, high), tick, start, stop, loop_en, song_len (last address
//   per channel), rom_req/rom_ch/rom_addr (registered read), rom_q ({on, note, delay},
//   valid the cycle after rom_req), note_on/note (per channel), busy, done (pulse).
module rom_sequencer_mc #(
    parameter int CHANNELS   = 4,
    parameter int ADDR_BITS  = 10,
    parameter int NOTE_BITS  = 7,
    parameter int DELAY_BITS = 12,
    localparam int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int Q_BITS    = 1 + NOTE_BITS + DELAY_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          loop_en,
    input  logic [CHANNELS*ADDR_BITS-1:0] song_len,
    output logic                          rom_req,
    output logic [CH_BITS-1:0]            rom_ch,
    output logic [ADDR_BITS-1:0]          rom_addr,
    input  logic [Q_BITS-1:0]             rom_q,
    output logic [CHANNELS-1:0]           note_on,
    output logic [CHANNELS*NOTE_BITS-1:0] note,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic {T_IDLE, T_RUN} top_t;
    typedef enum logic {F_REQ, F_CAP} fetch_t;

    top_t   top_q, top_d;
    fetch_t fetch_q, fetch_d;

    logic [ADDR_BITS-1:0]  ptr_q  [CHANNELS];
    logic [ADDR_BITS-1:0]  ptr_d  [CHANNELS];
    logic [DELAY_BITS-1:0] cnt_q  [CHANNELS];
    logic [DELAY_BITS-1:0] cnt_d  [CHANNELS];
    logic [NOTE_BITS-1:0]  note_q [CHANNELS];
    logic [NOTE_BITS-1:0]  note_d [CHANNELS];
    logic [CHANNELS-1:0]   pend_q, pend_d, fin_q, fin_d;
    logic [CHANNELS-1:0]   last_q, last_d, on_q, on_d;
    logic [CH_BITS-1:0]    rr_q, rr_d, ch_d, pick_ch;
    logic [ADDR_BITS-1:0]  addr_d;
    logic                  req_d, done_d, pick_ok;

    logic                  q_on;
    logic [NOTE_BITS-1:0]  q_note;
    logic [DELAY_BITS-1:0] q_delay;

    logic running, all_fin, launch, can_issue;

    assign q_on      = rom_q[Q_BITS-1];
    assign q_note    = rom_q[DELAY_BITS +: NOTE_BITS];
    assign q_delay   = rom_q[DELAY_BITS-1:0];
    assign running   = (top_q == T_RUN);
    assign all_fin   = &fin_q;
    assign launch    = (top_q == T_IDLE) && start && !stop;
    // A new request may be decided on any cycle that is not itself a request cycle.
    assign can_issue = ((fetch_q == F_REQ) && !rom_req) || (fetch_q == F_CAP);

    // Round-robin pick, searching from the channel after the last one served.
    always_comb begin
        int idx;
        idx     = 0;
        pick_ok = 1'b0;
        pick_ch = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = (int'(rr_q) + k) % CHANNELS;
            if (!pick_ok && pend_q[idx]) begin
                pick_ok = 1'b1;
                pick_ch = CH_BITS'(idx);
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q    <= T_IDLE;
            fetch_q  <= F_REQ;
            pend_q   <= '0;
            fin_q    <= '0;
            last_q   <= '0;
            on_q     <= '0;
            rr_q     <= '0;
            rom_req  <= 1'b0;
            rom_ch   <= '0;
            rom_addr <= '0;
            done     <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                ptr_q[c]  <= '0;
                cnt_q[c]  <= '0;
                note_q[c] <= '0;
            end
        end else begin
            top_q    <= top_d;
            fetch_q  <= fetch_d;
            pend_q   <= pend_d;
            fin_q    <= fin_d;
            last_q   <= last_d;
            on_q     <= on_d;
            rr_q     <= rr_d;
            rom_req  <= req_d;
            rom_ch   <= ch_d;
            rom_addr <= addr_d;
            done     <= done_d;
            for (int c = 0; c < CHANNELS; c++) begin
                ptr_q[c]  <= ptr_d[c];
                cnt_q[c]  <= cnt_d[c];
                note_q[c] <= note_d[c];
            end
        end
    end

    // Next-state logic for both FSMs
    always_comb begin
        top_d = top_q;
        unique case (top_q)
            T_IDLE: if (start && !stop) top_d = T_RUN;
            T_RUN:  if (stop || all_fin) top_d = T_IDLE;
        endcase
        fetch_d = F_REQ;
        if (running && !stop && !all_fin) begin
            unique case (fetch_q)
                F_REQ: fetch_d = rom_req ? F_CAP : F_REQ;
                F_CAP: fetch_d = F_REQ;
            endcase
        end
    end

    // Output / channel datapath logic
    always_comb begin
        logic become;
        become = 1'b0;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        note_d = note_q;
        pend_d = pend_q;
        fin_d  = fin_q;
        last_d = last_q;
        on_d   = on_q;
        rr_d   = rr_q;
        req_d  = 1'b0;
        ch_d   = rom_ch;
        addr_d = rom_addr;
        done_d = 1'b0;
        if (launch) begin
            // Channel 0 is requested straight away; the rest wait their turn.
            for (int c = 0; c < CHANNELS; c++) begin
                ptr_d[c] = '0;
                cnt_d[c] = '0;
            end
            pend_d    = '1;
            pend_d[0] = 1'b0;
            fin_d     = '0;
            last_d    = '0;
            rr_d      = '0;
            req_d     = 1'b1;
            ch_d      = '0;
            addr_d    = '0;
        end else if (running && stop) begin
            on_d = '0;
        end else if (running && all_fin) begin
            done_d = 1'b1;
        end else if (running) begin
            for (int c = 0; c < CHANNELS; c++) begin
                become = 1'b0;
                if ((fetch_q == F_CAP) && (rom_ch == CH_BITS'(c))) begin
                    on_d[c]   = q_on;
                    note_d[c] = q_note;
                    cnt_d[c]  = q_delay;
                    if (ptr_q[c] != song_len[c*ADDR_BITS +: ADDR_BITS])
                        ptr_d[c] = ptr_q[c] + ADDR_BITS'(1);
                    else
                        last_d[c] = 1'b1;
                    become = (q_delay == '0);
                end else if (tick && !pend_q[c] && !fin_q[c] &&
                             (cnt_q[c] != '0)) begin
                    cnt_d[c] = cnt_q[c] - DELAY_BITS'(1);
                    become   = (cnt_q[c] == DELAY_BITS'(1));
                end
                if (become) begin
                    if (!last_d[c]) begin
                        pend_d[c] = 1'b1;
                    end else if (loop_en) begin
                        ptr_d[c]  = '0;
                        last_d[c] = 1'b0;
                        pend_d[c] = 1'b1;
                    end else begin
                        fin_d[c] = 1'b1;
                        on_d[c]  = 1'b0;
                    end
                end
            end
            if (can_issue && pick_ok) begin
                req_d           = 1'b1;
                ch_d            = pick_ch;
                addr_d          = ptr_q[pick_ch];
                pend_d[pick_ch] = 1'b0;
                rr_d            = pick_ch;
            end
        end
    end

    always_comb begin
        note = '0;
        for (int c = 0; c < CHANNELS; c++)
            note[c*NOTE_BITS +: NOTE_BITS] = note_q[c];
    end

    assign note_on = on_q;
    assign busy    = running;

endmodule

// File: tb/tb_rom_sequencer_mc.sv
// tb_rom_sequencer_mc: directed bench for rom_sequencer_mc with a small ROM model.
// Ports: none; drives the DUT and prints one summary line.
module tb_rom_sequencer_mc;

    localparam int CH = 4;
    localparam int AB = 10;
    localparam int NB = 7;
    localparam int DB = 12;
    localparam int QB = 1 + NB + DB;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tick = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             loop_en = 1'b0;
    logic [CH*AB-1:0] song_len = '0;
    logic             rom_req;
    logic [1:0]       rom_ch;
    logic [AB-1:0]    rom_addr;
    logic [QB-1:0]    rom_q = '0;
    logic [CH-1:0]    note_on;
    logic [CH*NB-1:0] note;
    logic             busy;
    logic             done;

    logic [QB-1:0] rom [0:3][0:3];

    int n_chk = 0;
    int n_fail = 0;

    rom_sequencer_mc #(
        .CHANNELS(CH), .ADDR_BITS(AB), .NOTE_BITS(NB), .DELAY_BITS(DB)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
        .loop_en(loop_en), .song_len(song_len), .rom_req(rom_req),
        .rom_ch(rom_ch), .rom_addr(rom_addr), .rom_q(rom_q),
        .note_on(note_on), .note(note), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data appears the cycle after the strobe.
    always @(posedge clk)
        if (rom_req) rom_q <= rom[rom_ch][rom_addr[1:0]];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic          start;
        logic          tick;
        logic          req;
        logic [1:0]    ch;
        logic [AB-1:0] addr;
        logic          busy;
        logic          done;
        logic [3:0]    on;
        logic [NB-1:0] n0;
    } vec_t;

    vec_t vt [27];

    function automatic vec_t mk(input logic s, input logic t, input logic r,
                                input int c, input int a, input logic b,
                                input logic d, input logic [3:0] o, input int n);
        vec_t v;
        v.start = s;
        v.tick  = t;
        v.req   = r;
        v.ch    = 2'(c);
        v.addr  = AB'(a);
        v.busy  = b;
        v.done  = d;
        v.on    = o;
        v.n0    = NB'(n);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [25:0]    act_v, exp_v;
    logic [CH*NB-1:0] snap;
    logic [AB-1:0]  seen [6];
    int got, dcnt, found;

    initial begin
        // One-shot table on channel 0; others hold a single silent zero-delay entry.
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 4; a++)
                rom[c][a] = '0;
        rom[0][0] = {1'b1, 7'd60, 12'd3};
        rom[0][1] = {1'b1, 7'd62, 12'd0};
        rom[0][2] = {1'b0, 7'd0,  12'd2};
        song_len  = {10'd0, 10'd0, 10'd0, 10'd2};

        //             st tk rq ch ad bs dn on       n0
        vt[0]  = mk(1, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
        vt[1]  = mk(0, 0, 1, 0, 0, 1, 0, 4'b0000, 0);
        vt[2]  = mk(0, 0, 0, 0, 0, 1, 0, 4'b0000, 0);
        vt[3]  = mk(0, 1, 1, 1, 0, 1, 0, 4'b0001, 60);
        vt[4]  = mk(0, 0, 0, 1, 0, 1, 0, 4'b0001, 60);
        vt[5]  = mk(0, 0, 1, 2, 0, 1, 0, 4'b0001, 60);
        vt[6]  = mk(0, 0, 0, 2, 0, 1, 0, 4'b0001, 60);
        vt[7]  = mk(0, 1, 1, 3, 0, 1, 0, 4'b0001, 60);
        vt[8]  = mk(0, 0, 0, 3, 0, 1, 0, 4'b0001, 60);
        vt[9]  = mk(0, 0, 0, 3, 0, 1, 0, 4'b0001, 60);
        vt[10] = mk(0, 0, 0, 3, 0, 1, 0, 4'b0001, 60);
        vt[11] = mk(0, 1, 0, 3, 0, 1, 0, 4'b0001, 60);
        vt[12] = mk(0, 0, 0, 3, 0, 1, 0, 4'b0001, 60);
        vt[13] = mk(0, 0, 1, 0, 1, 1, 0, 4'b0001, 60);
        vt[14] = mk(0, 0, 0, 0, 1, 1, 0, 4'b0001, 60);
        vt[15] = mk(0, 1, 0, 0, 1, 1, 0, 4'b0001, 62);
        vt[16] = mk(0, 0, 1, 0, 2, 1, 0, 4'b0001, 62);
        vt[17] = mk(0, 0, 0, 0, 2, 1, 0, 4'b0001, 62);
        vt[18] = mk(0, 0, 0, 0, 2, 1, 0, 4'b0000, 0);
        vt[19] = mk(0, 1, 0, 0, 2, 1, 0, 4'b0000, 0);
        vt[20] = mk(0, 0, 0, 0, 2, 1, 0, 4'b0000, 0);
        vt[21] = mk(0, 0, 0, 0, 2, 1, 0, 4'b0000, 0);
        vt[22] = mk(0, 0, 0, 0, 2, 1, 0, 4'b0000, 0);
        vt[23] = mk(0, 1, 0, 0, 2, 1, 0, 4'b0000, 0);
        vt[24] = mk(0, 0, 0, 0, 2, 1, 0, 4'b0000, 0);
        vt[25] = mk(0, 0, 0, 0, 2, 0, 1, 4'b0000, 0);
        vt[26] = mk(0, 0, 0, 0, 2, 0, 0, 4'b0000, 0);

        repeat (2) @(negedge clk);
        check("reset_outputs",
              {rom_req, rom_ch, rom_addr, note_on, note, busy, done}, '0);
        reset = 1'b0;

        // One-shot song, cycle by cycle
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            act_v = {rom_req, rom_ch, rom_addr, busy, done, note_on, note[NB-1:0]};
            exp_v = {vt[i].req, vt[i].ch, vt[i].addr, vt[i].busy, vt[i].done,
                     vt[i].on, vt[i].n0};
            check($sformatf("oneshot_cycle%0d", i), act_v, exp_v);
            start = vt[i].start;
            tick  = vt[i].tick;
        end
        start = 1'b0;
        tick  = 1'b0;

        // Looping: channel 0 table of two entries
        rom[0][0] = {1'b1, 7'd10, 12'd1};
        rom[0][1] = {1'b1, 7'd11, 12'd1};
        song_len  = {10'd0, 10'd0, 10'd0, 10'd1};
        loop_en   = 1'b1;
        for (int i = 0; i < 6; i++) seen[i] = '1;
        @(negedge clk);
        start = 1'b1;
        got  = 0;
        dcnt = 0;
        for (int cyc = 0; cyc < 300 && got < 6; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            tick  = (cyc % 4 == 3);
            if (done) dcnt++;
            if (rom_req && rom_ch == 2'd0) begin
                seen[got] = rom_addr;
                got++;
            end
        end
        tick = 1'b0;
        check("loop_req_count", got, 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("loop_addr%0d", i), seen[i], AB'(i % 2));
        check("loop_no_done", dcnt, 0);
        check("loop_busy", busy, 1'b1);

        // Stop while a channel-0 fetch is in flight
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            @(negedge clk);
            tick = (k % 4 == 3);
            if (rom_req && rom_ch == 2'd0) found = 1;
        end
        tick = 1'b0;
        check("stop_found_req", found, 1);
        snap = note;
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy_low", busy, 1'b0);
        check("stop_note_on", note_on, 4'b0000);
        check("stop_late_q_ignored", note, snap);
        check("stop_req_low", rom_req, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_addr0", {rom_req, rom_ch, rom_addr, busy},
              {1'b1, 2'd0, 10'd0, 1'b1});
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_again_busy", busy, 1'b0);

        // start and stop together in IDLE: stop wins
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_same", {busy, rom_req}, 2'b00);

        // Tick coincident with capture of a delay-5 entry
        loop_en   = 1'b0;
        rom[0][0] = {1'b1, 7'd50, 12'd5};
        song_len  = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("d5_request", {rom_req, rom_ch, rom_addr}, {1'b1, 2'd0, 10'd0});
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("d5_captured", {note_on[0], note[NB-1:0]}, {1'b1, 7'd50});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
        end
        check("d5_after4", note_on[0], 1'b1);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        check("d5_after5", note_on[0], 1'b0);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (done) found = 1;
        end
        check("d5_done_seen", found, 1);
        check("d5_busy_low", busy, 1'b0);

        // Asynchronous reset mid-song
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_note_on", note_on[0], 1'b1);
        #2 reset = 1'b1;
        #1 check("rst_async_outputs",
                 {rom_req, rom_ch, rom_addr, note_on, note, busy, done}, '0);
        #1 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("rst_idle%0d", k), {busy, rom_req}, 2'b00);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_restart", {rom_req, rom_addr, busy}, {1'b1, 10'd0, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
